ft245_fifo_ctrl: RTL

Sequencer for the FT245-style parallel USB FIFO bus (8-bit bidirectional data, RXF#/TXE# flags, RD/WR strobes, output-enable for the pad tristate). It sits between the top-level pads/flag synchronizers and the SoC core. It turns two byte streams (TX in, RX out) into correctly timed FIFO bus cycles. When both directions are pending, it arbitrates between read and write round-robin.

---
 rtl/ft245_pkg.sv | 28 ++
 rtl/ft245_fifo_ctrl.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/ft245_pkg.sv
// Shared types and default bus timing for the FT245 FIFO sequencer.
package ft245_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_STROBE,
        ST_WR_SETUP,
        ST_WR_STROBE,
        ST_WR_HOLD,
        ST_GAP
    } state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } op_e;

    localparam int unsigned RD_CYCLES  = 4;
    localparam int unsigned WR_SETUP   = 1;
    localparam int unsigned WR_CYCLES  = 4;
    localparam int unsigned GAP_CYCLES = 3;

    // Down-counter reload value: a state lasting n cycles exits when the count hits zero.
    function automatic logic [3:0] cnt_load(input int unsigned n);
        return 4'(n - 1);
    endfunction

endpackage

// File: rtl/ft245_fifo_ctrl.sv
// FT245 parallel FIFO bus sequencer: turns a TX byte stream and an RX byte stream
// into timed RD/WR bus cycles with round-robin arbitration between directions.
module ft245_fifo_ctrl #(
    parameter int unsigned RD_CYCLES  = ft245_pkg::RD_CYCLES,
    parameter int unsigned WR_SETUP   = ft245_pkg::WR_SETUP,
    parameter int unsigned WR_CYCLES  = ft245_pkg::WR_CYCLES,
    parameter int unsigned GAP_CYCLES = ft245_pkg::GAP_CYCLES
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] uart_rdata,
    output logic [7:0] uart_wdata,
    input  logic       uart_rxf,
    input  logic       uart_txe,
    output logic       uart_rd,
    output logic       uart_wr,
    output logic       uart_oe,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy
);
    import ft245_pkg::*;

    state_e     state_q;
    logic [3:0] cnt_q;
    op_e        last_op_q;
    logic [7:0] tx_buf_q;
    logic       tx_full_q;
    logic [7:0] rx_data_q;
    logic       rx_valid_q;
    logic       rd_q;
    logic       wr_q;
    logic       oe_q;
    logic [7:0] wdata_q;

    logic rd_ok;
    logic wr_ok;
    logic take_rd;

    assign rd_ok   = ~uart_rxf & ~rx_valid_q;
    assign wr_ok   = ~uart_txe & tx_full_q;
    assign take_rd = rd_ok & (~wr_ok | (last_op_q == OP_WRITE));

    // NOTE: strobes and oe are flops on the async reset, so asserting rst_n drops
    // them immediately without waiting for a clock edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            last_op_q  <= OP_WRITE;
            tx_buf_q   <= '0;
            tx_full_q  <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rd_q       <= 1'b0;
            wr_q       <= 1'b0;
            oe_q       <= 1'b0;
            wdata_q    <= '0;
        end else begin
            if (tx_valid && !tx_full_q) begin
                tx_buf_q  <= tx_data;
                tx_full_q <= 1'b1;
            end
            if (rx_valid_q && rx_ready) begin
                rx_valid_q <= 1'b0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (take_rd) begin
                        state_q   <= ST_RD_STROBE;
                        cnt_q     <= cnt_load(RD_CYCLES);
                        rd_q      <= 1'b1;
                        last_op_q <= OP_READ;
                    end else if (wr_ok) begin
                        state_q   <= ST_WR_SETUP;
                        cnt_q     <= cnt_load(WR_SETUP);
                        oe_q      <= 1'b1;
                        wdata_q   <= tx_buf_q;
                        last_op_q <= OP_WRITE;
                    end
                end
                ST_RD_STROBE: begin
                    if (cnt_q == '0) begin
                        rx_data_q  <= uart_rdata;
                        rx_valid_q <= 1'b1;
                        rd_q       <= 1'b0;
                        state_q    <= ST_GAP;
                        cnt_q      <= cnt_load(GAP_CYCLES);
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_WR_SETUP: begin
                    if (cnt_q == '0) begin
                        wr_q    <= 1'b1;
                        state_q <= ST_WR_STROBE;
                        cnt_q   <= cnt_load(WR_CYCLES);
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_WR_STROBE: begin
                    if (cnt_q == '0) begin
                        wr_q    <= 1'b0;
                        state_q <= ST_WR_HOLD;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                ST_WR_HOLD: begin
                    // The byte is on the bus and latched by the FIFO; free the holding register.
                    tx_full_q <= 1'b0;
                    oe_q      <= 1'b0;
                    state_q   <= ST_GAP;
                    cnt_q     <= cnt_load(GAP_CYCLES);
                end
                ST_GAP: begin
                    if (cnt_q == '0) begin
                        state_q <= ST_IDLE;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    rd_q    <= 1'b0;
                    wr_q    <= 1'b0;
                    oe_q    <= 1'b0;
                end
            endcase
        end
    end

    assign uart_rd    = rd_q;
    assign uart_wr    = wr_q;
    assign uart_oe    = oe_q;
    assign uart_wdata = wdata_q;
    assign rx_data    = rx_data_q;
    assign rx_valid   = rx_valid_q;
    assign tx_ready   = ~tx_full_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
